// File: rtl/histogram_compressor.sv
// Bins a stream of {a,b} bit pairs into four occurrence counts per frame. Counts update the cycle after each accepted pair.
// Done pulses one cycle after the terminating edge. There is no backpressure: every valid pair seen in COUNT is accepted.
module histogram_compressor #(
    parameter int STREAM_LENGTH = 128,
    parameter int COUNTER_WIDTH = $clog2(STREAM_LENGTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_compress,
    input  logic                     stream_a,
    input  logic                     stream_b,
    input  logic                     valid_in,
    input  logic                     frame_end,
    output logic [COUNTER_WIDTH-1:0] count_00,
    output logic [COUNTER_WIDTH-1:0] count_01,
    output logic [COUNTER_WIDTH-1:0] count_10,
    output logic [COUNTER_WIDTH-1:0] count_11,
    output logic [COUNTER_WIDTH-1:0] total_pairs,
    output logic                     busy,
    output logic                     compress_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   state_q;
    logic                     busy_q;
    logic                     done_q;
    logic [COUNTER_WIDTH-1:0] c00_q, c01_q, c10_q, c11_q, total_q;
    logic [COUNTER_WIDTH-1:0] c00_d, c01_d, c10_d, c11_d, total_d;

    logic accept;
    logic last_pair;
    logic terminate;
    logic clear;

    assign accept    = (state_q == COUNT) && valid_in;
    // The pair that fills the frame ends it even without frame_end.
    assign last_pair = accept && (total_q == COUNTER_WIDTH'(STREAM_LENGTH - 1));
    assign terminate = (state_q == COUNT) && (frame_end || last_pair);
    assign clear     = (state_q == IDLE) && start_compress;

    always_comb begin
        c00_d   = c00_q;
        c01_d   = c01_q;
        c10_d   = c10_q;
        c11_d   = c11_q;
        total_d = total_q;
        if (clear) begin
            c00_d   = '0;
            c01_d   = '0;
            c10_d   = '0;
            c11_d   = '0;
            total_d = '0;
        end else if (accept) begin
            total_d = total_q + COUNTER_WIDTH'(1);
            unique case ({stream_a, stream_b})
                2'b00:   c00_d = c00_q + COUNTER_WIDTH'(1);
                2'b01:   c01_d = c01_q + COUNTER_WIDTH'(1);
                2'b10:   c10_d = c10_q + COUNTER_WIDTH'(1);
                default: c11_d = c11_q + COUNTER_WIDTH'(1);
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c00_q   <= '0;
            c01_q   <= '0;
            c10_q   <= '0;
            c11_q   <= '0;
            total_q <= '0;
        end else begin
            c00_q   <= c00_d;
            c01_q   <= c01_d;
            c10_q   <= c10_d;
            c11_q   <= c11_d;
            total_q <= total_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_compress) begin
                        state_q <= COUNT;
                        busy_q  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (terminate) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count_00      = c00_q;
    assign count_01      = c01_q;
    assign count_10      = c10_q;
    assign count_11      = c11_q;
    assign total_pairs   = total_q;
    assign busy          = busy_q;
    assign compress_done = done_q;

endmodule

// File: tb/tb_histogram_compressor.sv
// Directed bench: each frame's expected histogram is queued when the frame is issued and checked on compress_done.
module tb_histogram_compressor;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_compress = 1'b0;
    logic          stream_a = 1'b0;
    logic          stream_b = 1'b0;
    logic          valid_in = 1'b0;
    logic          frame_end = 1'b0;
    logic [CW-1:0] count_00, count_01, count_10, count_11, total_pairs;
    logic          busy, compress_done;

    typedef struct {
        int c00;
        int c01;
        int c10;
        int c11;
        int tot;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   dones = 0;

    histogram_compressor dut (
        .clk            (clk),
        .rst            (rst),
        .start_compress (start_compress),
        .stream_a       (stream_a),
        .stream_b       (stream_b),
        .valid_in       (valid_in),
        .frame_end      (frame_end),
        .count_00       (count_00),
        .count_01       (count_01),
        .count_10       (count_10),
        .count_11       (count_11),
        .total_pairs    (total_pairs),
        .busy           (busy),
        .compress_done  (compress_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic a, input logic b, input logic v, input logic fe);
        start_compress = s;
        stream_a       = a;
        stream_b       = b;
        valid_in       = v;
        frame_end      = fe;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c00, input int c01, input int c10, input int c11);
        exp_t e;
        e.c00 = c00;
        e.c01 = c01;
        e.c10 = c10;
        e.c11 = c11;
        e.tot = c00 + c01 + c10 + c11;
        sb.push_back(e);
    endtask

    // Monitor: invariant every cycle, histogram on each done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            chk("bin_sum_vs_total", int'(count_00) + int'(count_01) + int'(count_10) + int'(count_11),
                int'(total_pairs));
            if (compress_done) begin
                exp_t e;
                dones++;
                chk("busy_at_done", int'(busy), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_count_00", int'(count_00), e.c00);
                    chk("done_count_01", int'(count_01), e.c01);
                    chk("done_count_10", int'(count_10), e.c10);
                    chk("done_count_11", int'(count_11), e.c11);
                    chk("done_total", int'(total_pairs), e.tot);
                end
            end
        end
    end

    initial begin
        logic [1:0] seq [19];
        logic [1:0] p;
        int         rem [4];
        int         k;
        int         left;

        #2;
        chk("reset_count_00", int'(count_00), 0);
        chk("reset_total", int'(total_pairs), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(compress_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 0, 0, 1, 1);
        chk("idle_ignores_valid", int'(total_pairs), 0);

        // Frame 1: 10 x 00, then frame_end without a pair.
        push(10, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        chk("busy_after_start", int'(busy), 1);
        chk("start_pair_not_counted", int'(total_pairs), 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0);
        chk("live_count_00", int'(count_00), 10);
        cyc(0, 0, 0, 0, 1);
        chk("f1_done_latency", int'(compress_done), 1);
        cyc(0, 0, 0, 0, 0);
        chk("f1_done_one_cycle", int'(compress_done), 0);
        chk("f1_busy_low", int'(busy), 0);

        // Frame 2: 5/7/4/3 in permuted order with gaps; last pair carries frame_end.
        for (int i = 0; i < 19; i++) seq[i] = (i < 5) ? 2'd0 : (i < 12) ? 2'd1 : (i < 16) ? 2'd2 : 2'd3;
        push(5, 7, 4, 3);
        cyc(1, 1, 1, 1, 0);
        for (int i = 0; i < 19; i++) begin
            p = seq[(i * 4) % 19];
            cyc(0, p[1], p[0], 1, (i == 18) ? 1'b1 : 1'b0);
            if (i % 2 == 0 && i != 18) cyc(0, 1, 1, 0, 0);
        end
        chk("f2_done_latency", int'(compress_done), 1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 0);
        chk("idle_start_after_done_gap", int'(busy), 1);

        // Frame 3 (already started): saturate at STREAM_LENGTH.
        push(0, 0, 0, 128);
        for (int i = 0; i < 200; i++) begin
            cyc(0, 1, 1, 1, 0);
            if (i == 126) chk("f3_not_done_at_127", int'(compress_done), 0);
            if (i == 127) chk("f3_done_after_128", int'(compress_done), 1);
        end
        chk("f3_count_11_held", int'(count_11), 128);
        chk("f3_total_held", int'(total_pairs), 128);

        // Frame 4a: empty frame.
        push(0, 0, 0, 0);
        cyc(1, 0, 1, 1, 0);
        chk("f4a_cleared", int'(count_11), 0);
        cyc(0, 0, 0, 0, 1);
        chk("f4a_done", int'(compress_done), 1);
        cyc(0, 0, 0, 0, 0);

        // Frame 4b: start_compress mid-frame does not restart.
        push(0, 6, 1, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0);
        cyc(1, 0, 1, 1, 0);
        chk("f4b_no_restart", int'(total_pairs), 4);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 1, 0, 1, 1);
        cyc(1, 0, 0, 1, 0);
        chk("done_ignores_start", int'(busy), 0);

        // Frame 5: asynchronous reset after 6 pairs, then a single 10 pair.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
        chk("f5_pre_reset", int'(count_00), 6);
        rst = 1'b1;
        #1;
        chk("async_rst_count_00", int'(count_00), 0);
        chk("async_rst_total", int'(total_pairs), 0);
        chk("async_rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 0, 0, 1, 1);
        chk("post_rst_idle", int'(busy), 0);
        push(0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 0);

        // Frame 6: decompressor-style round trip of 20/15/12/8.
        rem[0] = 20;
        rem[1] = 15;
        rem[2] = 12;
        rem[3] = 8;
        k      = 0;
        left   = 55;
        push(20, 15, 12, 8);
        cyc(1, 0, 0, 0, 0);
        while (left > 0) begin
            if ($urandom_range(0, 3) == 0) begin
                cyc(0, 1'($urandom), 1'($urandom), 0, 0);
            end else begin
                while (rem[k] == 0) k = (k + 1) % 4;
                p = 2'(k);
                cyc(0, p[1], p[0], 1, 0);
                rem[k]--;
                left--;
                k = (k + 1) % 4;
            end
        end
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);

        chk("pending_expectations", sb.size(), 0);
        chk("done_pulses", dones, 7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
